// File: rtl/obstacle_animator.sv
// obstacle_animator: draws, waits, erases and moves one sprite lane; OBSTACLE_HIT_EN adds player overlap detection
module obstacle_animator #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int X_MAX = 160,
  parameter int START_X = 0,
  parameter int START_Y = 45,
  parameter bit START_DIR = 1'b1,
  parameter int STEP = 1,
  parameter int TICKS_PER_FRAME = 833333,
  parameter int FRAMES_PER_STEP = 8,
  parameter bit WRAP_MODE = 1'b0,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK,
  input  logic       resetn,
  input  logic       go,
  input  logic       pause,
  input  logic [2:0] colour_in,
  input  logic [7:0] px,
  input  logic [6:0] py,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic [7:0] obj_x,
  output logic       step_done,
  output logic       hit,
  output logic [2:0] current_state
);
  localparam int XR = X_MAX - SPRITE_W;
  localparam int TW = TICKS_PER_FRAME > 1 ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int FW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_RESET_WAIT = 3'd1,
    S_PLOT = 3'd2,
    S_RESET_COUNTER = 3'd3,
    S_COUNT = 3'd4,
    S_ERASE = 3'd5,
    S_UPDATE = 3'd6
  } state_t;
  state_t state, next;
  logic dir, nd;
  logic [3:0] cx, cy;
  logic [TW-1:0] tick;
  logic [FW-1:0] frame;
  logic [2:0] col;
  logic [7:0] nx;
  logic [8:0] ox9;
  logic scan, last_col, last_px, frame_done, right_over, left_under;
  assign scan = state == S_PLOT || state == S_ERASE;
  assign last_col = cx == 4'(SPRITE_W - 1);
  assign last_px = last_col && cy == 4'(SPRITE_H - 1);
  assign frame_done = tick == '0 && frame == FW'(FRAMES_PER_STEP - 1);
  assign ox9 = {1'b0, obj_x};
  assign right_over = ox9 + 9'(STEP) > 9'(XR);
  assign left_under = ox9 < 9'(STEP);
  assign x = obj_x + {4'b0, cx};
  assign y = 7'(START_Y) + {3'b0, cy};
  assign colour = state == S_ERASE ? BG_COLOUR : col;
  assign writeEn = scan;
  assign step_done = state == S_UPDATE;
  assign current_state = state;
  // next position and direction, evaluated against the 9-bit origin so obj_x+STEP cannot overflow
  always_comb begin
    nx = dir ? (right_over ? (WRAP_MODE ? 8'd0 : 8'(XR)) : obj_x + 8'(STEP))
             : (left_under ? (WRAP_MODE ? 8'(XR) : 8'd0) : obj_x - 8'(STEP));
    nd = WRAP_MODE ? dir : (dir ? !right_over : left_under);
  end
  // state register
  always_ff @(posedge CLOCK)
    state <= resetn ? next : S_RESET;
  // next-state logic; unused codes fall back to RESET
  always_comb begin
    next = state;
    case (state)
      S_RESET:         next = go ? S_RESET_WAIT : S_RESET;
      S_RESET_WAIT:    next = go ? S_RESET_WAIT : S_PLOT;
      S_PLOT:          next = last_px ? S_RESET_COUNTER : S_PLOT;
      S_RESET_COUNTER: next = S_COUNT;
      S_COUNT:         next = (!pause && frame_done) ? S_ERASE : S_COUNT;
      S_ERASE:         next = last_px ? S_UPDATE : S_ERASE;
      S_UPDATE:        next = S_PLOT;
      default:         next = S_RESET;
    endcase
  end
  // pixel scan, frame wait counters, colour latch and sprite motion
  always_ff @(posedge CLOCK) begin
    if (!resetn) begin
      obj_x <= 8'(START_X);
      dir <= START_DIR;
      cx <= '0;
      cy <= '0;
      tick <= '0;
      frame <= '0;
      col <= BG_COLOUR;
    end else begin
      if (scan) begin
        cx <= last_col ? 4'd0 : cx + 4'd1;
        cy <= last_px ? 4'd0 : (last_col ? cy + 4'd1 : cy);
      end
      if (state == S_RESET_WAIT && !go)
        col <= colour_in;
      if (state == S_UPDATE) begin
        col <= colour_in;
        obj_x <= nx;
        dir <= nd;
      end
      if (state == S_RESET_COUNTER) begin
        tick <= TW'(TICKS_PER_FRAME - 1);
        frame <= '0;
      end else if (state == S_COUNT && !pause) begin
        tick <= tick == '0 ? TW'(TICKS_PER_FRAME - 1) : tick - 1'b1;
        if (tick == '0)
          frame <= frame + 1'b1;
      end
    end
  end
`ifdef OBSTACLE_HIT_EN
  // player overlap against the committed origin, one cycle behind px/py
  always_ff @(posedge CLOCK) begin
    if (!resetn)
      hit <= 1'b0;
    else if (state != S_RESET)
      hit <= {1'b0, px} >= ox9 && {1'b0, px} < ox9 + 9'(SPRITE_W) &&
             py >= 7'(START_Y) && {1'b0, py} < 8'(START_Y + SPRITE_H);
  end
`else
  logic unused_player;
  assign unused_player = ^{px, py};
  assign hit = 1'b0;
`endif
endmodule

// File: tb/tb_obstacle_animator.sv
// tb_obstacle_animator: period-based model of the lane animation checked every cycle, plus literal spot checks
module tb_obstacle_animator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, go, pause;
  logic [2:0] colour_in;
  logic [7:0] px;
  logic [6:0] py;
  logic [7:0] x_a, x_b, x_c, ox_a, ox_b, ox_c;
  logic [6:0] y_a, y_b, y_c;
  logic [2:0] col_a, col_b, col_c, st_a, st_b, st_c;
  logic we_a, we_b, we_c, sd_a, sd_b, sd_c, hit_a, hit_b, hit_c;
  int checks = 0, failures = 0;
  int t = 0;
  bit active = 1'b0;
  int cnt4[4] = '{default: 0};
  int sd_cnt = 0;
  int k, p, es, pix, pos;
  bit we;
  int first_x[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int first_y[8] = '{45, 45, 45, 45, 46, 46, 46, 46};
  obstacle_animator #(.SPRITE_W(4), .SPRITE_H(2), .X_MAX(12), .START_X(0), .START_Y(45), .START_DIR(1'b1),
    .STEP(1), .TICKS_PER_FRAME(3), .FRAMES_PER_STEP(2), .WRAP_MODE(1'b0), .BG_COLOUR(3'b000)) dut_a (
    .CLOCK(clk), .resetn(resetn), .go(go), .pause(pause), .colour_in(colour_in), .px(px), .py(py),
    .x(x_a), .y(y_a), .colour(col_a), .writeEn(we_a), .obj_x(ox_a), .step_done(sd_a), .hit(hit_a),
    .current_state(st_a));
  obstacle_animator #(.SPRITE_W(4), .SPRITE_H(2), .X_MAX(12), .START_X(7), .START_Y(45), .START_DIR(1'b1),
    .STEP(3), .TICKS_PER_FRAME(3), .FRAMES_PER_STEP(2), .WRAP_MODE(1'b0), .BG_COLOUR(3'b000)) dut_b (
    .CLOCK(clk), .resetn(resetn), .go(go), .pause(pause), .colour_in(colour_in), .px(px), .py(py),
    .x(x_b), .y(y_b), .colour(col_b), .writeEn(we_b), .obj_x(ox_b), .step_done(sd_b), .hit(hit_b),
    .current_state(st_b));
  obstacle_animator #(.SPRITE_W(4), .SPRITE_H(2), .X_MAX(12), .START_X(8), .START_Y(45), .START_DIR(1'b1),
    .STEP(1), .TICKS_PER_FRAME(3), .FRAMES_PER_STEP(2), .WRAP_MODE(1'b1), .BG_COLOUR(3'b000)) dut_c (
    .CLOCK(clk), .resetn(resetn), .go(go), .pause(pause), .colour_in(colour_in), .px(px), .py(py),
    .x(x_c), .y(y_c), .colour(col_c), .writeEn(we_c), .obj_x(ox_c), .step_done(sd_c), .hit(hit_c),
    .current_state(st_c));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask
  // bounce trajectory of lane A: 0..8, held once at each edge while the direction flips
  function automatic int bounce_pos(input int kk);
    int m;
    m = kk % 18;
    return m <= 8 ? m : 17 - m;
  endfunction
  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (t < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (t != target) chk("wait_timeout", t, target);
  endtask
  // every cycle: 24-cycle period = 8 plot, 1 counter reset, 6 wait, 8 erase, 1 update
  always @(negedge clk) begin
    if (active) begin
      k = t / 24;
      p = t % 24;
      es = p < 8 ? 2 : p == 8 ? 3 : p < 15 ? 4 : p < 23 ? 5 : 6;
      we = es == 2 || es == 5;
      pix = es == 5 ? p - 15 : p;
      pos = bounce_pos(k);
      chk("state", st_a, es);
      chk("writeEn", we_a, we);
      chk("obj_x", ox_a, pos);
      chk("x", x_a, we ? pos + pix % 4 : pos);
      chk("y", y_a, we ? 45 + pix / 4 : 45);
      chk("colour", col_a, es == 5 ? 0 : (k == 0 ? 4 : 2));
      chk("step_done", sd_a, p == 23);
`ifndef OBSTACLE_HIT_EN
      chk("hit_tied", hit_a, 0);
`endif
      if (k < 4 && st_a == 3'd4) cnt4[k]++;
      if (k == 0 && sd_a) sd_cnt++;
      if (k == 0 && p < 8) begin
        chk("first_plot_x", x_a, first_x[p]);
        chk("first_plot_y", y_a, first_y[p]);
        chk("first_plot_colour", col_a, 4);
      end
      if (k == 0 && p == 15) chk("count_len", cnt4[0], 6);
      if (k == 2 && p == 15) chk("count_len_paused", cnt4[2], 26);
      if (k == 1 && p == 0) begin
        chk("first_move", ox_a, 1);
        chk("step_pulses", sd_cnt, 1);
        chk("b_clamp_right", ox_b, 8);
        chk("c_wrap_right", ox_c, 0);
      end
      if (k == 2 && p == 0) begin
        chk("b_move_left", ox_b, 5);
        chk("c_keep_right", ox_c, 1);
      end
      if (k == 9 && p == 0) chk("bounce_edge", ox_a, 8);
      if (k == 10 && p == 0) chk("bounce_back", ox_a, 7);
      if (!(es == 4 && pause)) t++;
    end
  end
  initial begin
    resetn = 1'b0;
    go = 1'b0;
    pause = 1'b0;
    colour_in = 3'b100;
    px = 8'd0;
    py = 7'd0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_state", st_a, 0);
    chk("rst_writeEn", we_a, 0);
    chk("rst_obj_x", ox_a, 0);
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 45);
    chk("rst_colour", col_a, 0);
    chk("rst_step_done", sd_a, 0);
    chk("rst_hit", hit_a, 0);
    @(posedge clk);
    #1 go = 1'b1;
    @(posedge clk);
    #1 chk("reset_wait", st_a, 1);
    @(posedge clk);
    #1 chk("reset_wait_hold", st_a, 1);
    go = 1'b0;
    @(posedge clk);
    #1 active = 1'b1;
    t = 0;
    colour_in = 3'b010;
    wait_t(29);
    px = 8'd4;
    py = 7'd46;
    @(posedge clk);
    #1;
`ifdef OBSTACLE_HIT_EN
    chk("hit_inside", hit_a, 1);
`else
    chk("hit_inside", hit_a, 0);
`endif
    px = 8'd5;
    @(posedge clk);
    #1 chk("hit_outside", hit_a, 0);
    px = 8'd0;
    py = 7'd0;
    wait_t(57);
    pause = 1'b1;
    repeat (20) @(posedge clk);
    #1 pause = 1'b0;
    wait_t(243);
    resetn = 1'b0;
    active = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_state", st_a, 0);
    chk("abort_writeEn", we_a, 0);
    chk("abort_obj_x", ox_a, 0);
    chk("abort_colour", col_a, 0);
    chk("abort_step_done", sd_a, 0);
    resetn = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
